// File: rtl/estado_mascota.sv
// -----------------------------------------------------------------------------
// estado_mascota
//   Chooses the face shown by the display from the four pet need levels.
//   Adds hysteresis before relaxing to a milder face, a blinking alert while a
//   critical face is shown, and death/revival of the pet.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   nivel_animo   in   [1:0] animo level (3 = full, 0 = empty)
//   nivel_hambre  in   [1:0] hambre level
//   nivel_sueno   in   [1:0] sueno level
//   nivel_salud   in   [1:0] salud level
//   btn_revivir   in   one-cycle revive pulse (already debounced)
//   cara          out  [2:0] face code, ordered by severity:
//                      0 FELIZ 1 NEUTRAL 2 TRISTE 3 CANSADO 4 HAMBRIENTO
//                      5 ENFERMO 6 MUERTO
//   alerta        out  blinking critical indicator
//   muerto        out  pet is dead
// -----------------------------------------------------------------------------
module estado_mascota #(
  parameter int TICK_CYCLES = 50,
  parameter int DWELL_TICKS = 3,
  parameter int DEATH_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] nivel_animo,
  input  logic [1:0] nivel_hambre,
  input  logic [1:0] nivel_sueno,
  input  logic [1:0] nivel_salud,
  input  logic       btn_revivir,
  output logic [2:0] cara,
  output logic       alerta,
  output logic       muerto
);

  localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DWW = $clog2(DWELL_TICKS + 1);
  localparam int DTW = $clog2(DEATH_TICKS + 1);

  localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [DWW-1:0] DWELL_MAX  = DWW'(DWELL_TICKS);
  localparam logic [DTW-1:0] DEATH_MAX  = DTW'(DEATH_TICKS);
  localparam logic [DTW-1:0] DEATH_LAST = DTW'(DEATH_TICKS - 1);

  typedef enum logic [2:0] {
    FELIZ      = 3'd0,
    NEUTRAL    = 3'd1,
    TRISTE     = 3'd2,
    CANSADO    = 3'd3,
    HAMBRIENTO = 3'd4,
    ENFERMO    = 3'd5,
    DIFUNTO    = 3'd6
  } cara_e;

  typedef enum logic {
    VIVO   = 1'b0,
    MUERTO = 1'b1
  } estado_e;

  // Registered copies of the levels; every decision uses these.
  logic [1:0]     animo_q, hambre_q, sueno_q, salud_q;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic [DTW-1:0] death_cnt_q, death_cnt_d, death_cnt_vivo;
  cara_e          cara_q, cara_d, cara_req;
  logic           alerta_q, alerta_d;
  estado_e        state_q, state_d;

  logic tick;
  logic salud_cero;
  logic todo_cero;
  logic death_trig;

  // ---------------------------------------------------------------------------
  // Free-running tick and the face requested by the current levels
  // ---------------------------------------------------------------------------
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    cara_req = NEUTRAL;
    if (salud_q <= 2'd1)       cara_req = ENFERMO;
    else if (hambre_q <= 2'd1) cara_req = HAMBRIENTO;
    else if (sueno_q <= 2'd1)  cara_req = CANSADO;
    else if (animo_q <= 2'd1)  cara_req = TRISTE;
    else if (animo_q == 2'd3 && hambre_q == 2'd3 &&
             sueno_q == 2'd3 && salud_q == 2'd3)
      cara_req = FELIZ;
  end

  // ---------------------------------------------------------------------------
  // Death detection
  // ---------------------------------------------------------------------------
  assign salud_cero = (salud_q == 2'd0);
  assign todo_cero  = salud_cero && (animo_q == 2'd0) &&
                      (hambre_q == 2'd0) && (sueno_q == 2'd0);

  // The tick that would bring the counter to DEATH_TICKS is the trigger, so
  // compare against the value one below before it increments.
  assign death_trig = tick && (todo_cero || (salud_cero && death_cnt_q == DEATH_LAST));

  always_comb begin
    death_cnt_vivo = death_cnt_q;
    if (!salud_cero)
      death_cnt_vivo = '0;
    else if (tick && death_cnt_q != DEATH_MAX)
      death_cnt_vivo = death_cnt_q + DTW'(1);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= VIVO;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VIVO:   if (death_trig)  state_d = MUERTO;
      MUERTO: if (btn_revivir) state_d = VIVO;
      default: state_d = VIVO;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Face, dwell, alert and death counter next values
  // ---------------------------------------------------------------------------
  always_comb begin
    cara_d      = cara_q;
    alerta_d    = alerta_q;
    dwell_d     = dwell_q;
    death_cnt_d = death_cnt_q;

    unique case (state_q)
      VIVO: begin
        death_cnt_d = death_cnt_vivo;
        if (death_trig) begin
          // Death overrides any face change pending this cycle.
          cara_d   = DIFUNTO;
          alerta_d = 1'b0;
          dwell_d  = '0;
        end else begin
          // Worse faces are taken at once; milder ones only after the dwell.
          if (cara_req > cara_q || (cara_req < cara_q && dwell_q == DWELL_MAX))
            cara_d = cara_req;

          // A face change restarts the dwell even when a tick lands with it.
          if (cara_d != cara_q)
            dwell_d = '0;
          else if (tick && dwell_q != DWELL_MAX)
            dwell_d = dwell_q + DWW'(1);

          // The blink phase keeps running across changes between critical
          // faces; it only restarts when entering from a non-critical face.
          if (cara_d < TRISTE)
            alerta_d = 1'b0;
          else if (cara_q < TRISTE)
            alerta_d = 1'b1;
          else
            alerta_d = alerta_q ^ tick;
        end
      end

      MUERTO: begin
        if (btn_revivir) begin
          cara_d      = cara_req;
          dwell_d     = '0;
          death_cnt_d = '0;
          alerta_d    = (cara_req >= TRISTE);
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state, including the level copies, is cleared by the async
    // reset so the block is in a known state the moment rst_n falls.
    if (!rst_n) begin
      animo_q     <= 2'd3;
      hambre_q    <= 2'd3;
      sueno_q     <= 2'd3;
      salud_q     <= 2'd3;
      tick_cnt_q  <= '0;
      dwell_q     <= '0;
      death_cnt_q <= '0;
      cara_q      <= FELIZ;
      alerta_q    <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values of all the others.
      animo_q     <= nivel_animo;
      hambre_q    <= nivel_hambre;
      sueno_q     <= nivel_sueno;
      salud_q     <= nivel_salud;
      tick_cnt_q  <= tick_cnt_d;
      dwell_q     <= dwell_d;
      death_cnt_q <= death_cnt_d;
      cara_q      <= cara_d;
      alerta_q    <= alerta_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cara   = cara_q;
    alerta = alerta_q;
    muerto = (state_q == MUERTO);
  end

endmodule

// File: tb/tb_estado_mascota.sv
// -----------------------------------------------------------------------------
// tb_estado_mascota
//   Directed stimulus for estado_mascota with small timing parameters. A pet
//   model derived from the behavioural rules is compared with the outputs on
//   every falling clock edge, and hand-computed expectations pin key moments.
// -----------------------------------------------------------------------------
module tb_estado_mascota;

  localparam int T  = 4;  // clk cycles per tick
  localparam int DW = 2;  // dwell ticks
  localparam int DT = 3;  // death ticks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] nivel_animo = 2'd0;
  logic [1:0] nivel_hambre = 2'd0;
  logic [1:0] nivel_sueno = 2'd0;
  logic [1:0] nivel_salud = 2'd0;
  logic       btn_revivir = 1'b0;
  logic [2:0] cara;
  logic       alerta;
  logic       muerto;

  int total = 0;
  int bad   = 0;

  estado_mascota #(
    .TICK_CYCLES(T),
    .DWELL_TICKS(DW),
    .DEATH_TICKS(DT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nivel_animo (nivel_animo),
    .nivel_hambre(nivel_hambre),
    .nivel_sueno (nivel_sueno),
    .nivel_salud (nivel_salud),
    .btn_revivir (btn_revivir),
    .cara        (cara),
    .alerta      (alerta),
    .muerto      (muerto)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pet model: plain integers, one update per rising edge
  // ---------------------------------------------------------------------------
  int m_phase  = 0;  // clocks since last tick
  int m_dwell  = 0;
  int m_dc     = 0;  // consecutive ticks with salud at 0
  int m_cara   = 0;
  int m_alerta = 0;
  int m_dead   = 0;
  int lv[4]    = '{3, 3, 3, 3};  // animo, hambre, sueno, salud as seen last clk

  function automatic int face_for(input int an, input int hb, input int su, input int sa);
    if (sa <= 1) return 5;
    if (hb <= 1) return 4;
    if (su <= 1) return 3;
    if (an <= 1) return 2;
    if (an == 3 && hb == 3 && su == 3 && sa == 3) return 0;
    return 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int  req;
    int  prev;
    bit  is_tick;
    if (!rst_n) begin
      m_phase = 0; m_dwell = 0; m_dc = 0;
      m_cara = 0; m_alerta = 0; m_dead = 0;
      lv = '{3, 3, 3, 3};
    end else begin
      is_tick = (m_phase == T - 1);
      m_phase = is_tick ? 0 : m_phase + 1;
      req = face_for(lv[0], lv[1], lv[2], lv[3]);
      if (m_dead == 0) begin
        if (lv[3] != 0) m_dc = 0;
        else if (is_tick && m_dc < DT) m_dc++;
        if (is_tick && ((lv[0] + lv[1] + lv[2] + lv[3] == 0) || (lv[3] == 0 && m_dc == DT))) begin
          m_dead = 1; m_cara = 6; m_alerta = 0; m_dwell = 0;
        end else begin
          prev = m_cara;
          if (req > m_cara || (req < m_cara && m_dwell >= DW)) m_cara = req;
          if (m_cara != prev) m_dwell = 0;
          else if (is_tick && m_dwell < DW) m_dwell++;
          if (m_cara < 2) m_alerta = 0;
          else if (prev < 2) m_alerta = 1;
          else if (is_tick) m_alerta = 1 - m_alerta;
        end
      end else if (btn_revivir) begin
        m_dead = 0; m_cara = req; m_dwell = 0; m_dc = 0;
        m_alerta = (req >= 2) ? 1 : 0;
      end
      lv = '{int'(nivel_animo), int'(nivel_hambre), int'(nivel_sueno), int'(nivel_salud)};
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_cara",   int'(cara),   m_cara);
      check("model_alerta", int'(alerta), m_alerta);
      check("model_muerto", int'(muerto), m_dead);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on falling edges)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lv(input int an, input int hb, input int su, input int sa);
    nivel_animo  = 2'(an);
    nivel_hambre = 2'(hb);
    nivel_sueno  = 2'(su);
    nivel_salud  = 2'(sa);
  endtask

  task automatic wait_cara(input int exp, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (int'(cara) == exp) break;
    end
    check(name, int'(cara), exp);
  endtask

  task automatic wait_muerto(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (muerto) break;
    end
    check(name, int'(muerto), 1);
  endtask

  task automatic pulse_revive();
    btn_revivir = 1'b1;
    step(1);
    btn_revivir = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin : stim
    int toggles;
    logic last_alerta;

    // 1. Reset held with empty levels, then released with full levels
    step(2);
    check("rst_cara",   int'(cara),   0);
    check("rst_alerta", int'(alerta), 0);
    check("rst_muerto", int'(muerto), 0);
    set_lv(3, 3, 3, 3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_cara", int'(cara), 0);
    end

    // 2. Escalation: two-clock latency, then blink at every tick
    set_lv(3, 1, 3, 3);
    step(1);
    check("esc_lat1_cara", int'(cara), 0);
    step(1);
    check("esc_cara",   int'(cara),   4);
    check("esc_alerta", int'(alerta), 1);
    toggles = 0;
    last_alerta = alerta;
    for (int i = 0; i < 2 * T; i++) begin
      step(1);
      if (alerta != last_alerta) toggles++;
      last_alerta = alerta;
    end
    check("blink_toggles", toggles, 2);

    // Dwell already satisfied, so relaxing is quick here
    set_lv(3, 3, 3, 3);
    wait_cara(0, 6, "relax_cara");

    // 3. Dwell: relax requested right after escalation
    set_lv(3, 1, 3, 3);
    wait_cara(4, 4, "dwell_esc_cara");
    set_lv(3, 3, 3, 3);
    step(4);
    check("dwell_hold_cara", int'(cara), 4);
    wait_cara(0, 10, "dwell_relax_cara");
    check("dwell_relax_alerta", int'(alerta), 0);
    set_lv(3, 2, 3, 3);
    step(1);
    check("neutral_lat1_cara", int'(cara), 0);
    step(1);
    check("neutral_cara", int'(cara), 1);

    // 4. Priority: salud wins over animo; relaxing to TRISTE waits for dwell
    set_lv(0, 3, 3, 1);
    step(2);
    check("prio_cara",   int'(cara),   5);
    check("prio_alerta", int'(alerta), 1);
    set_lv(0, 3, 3, 3);
    step(4);
    check("prio_hold_cara", int'(cara), 5);
    wait_cara(2, 10, "prio_relax_cara");
    check("prio_relax_muerto", int'(muerto), 0);

    // 5. Death by salud, revive while still sick, die again, full revive
    set_lv(3, 3, 3, 0);
    step(9);
    check("death_early_muerto", int'(muerto), 0);
    wait_muerto(8, "death_muerto");
    check("death_cara",   int'(cara),   6);
    check("death_alerta", int'(alerta), 0);
    pulse_revive();
    check("revive_sick_cara",   int'(cara),   5);
    check("revive_sick_muerto", int'(muerto), 0);
    check("revive_sick_alerta", int'(alerta), 1);
    step(8);
    check("redeath_early_muerto", int'(muerto), 0);
    wait_muerto(8, "redeath_muerto");
    check("redeath_cara", int'(cara), 6);
    set_lv(3, 3, 3, 3);
    step(2);
    check("dead_hold_cara", int'(cara), 6);
    pulse_revive();
    check("revive_ok_cara",   int'(cara),   0);
    check("revive_ok_alerta", int'(alerta), 0);
    check("revive_ok_muerto", int'(muerto), 0);
    pulse_revive();
    step(2);
    check("alive_btn_cara",   int'(cara),   0);
    check("alive_btn_alerta", int'(alerta), 0);
    check("alive_btn_muerto", int'(muerto), 0);

    // 6. All levels empty: death on the first tick, then async reset
    set_lv(0, 0, 0, 0);
    wait_muerto(6, "zero_muerto");
    check("zero_cara", int'(cara), 6);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_cara",   int'(cara),   0);
    check("async_rst_muerto", int'(muerto), 0);
    check("async_rst_alerta", int'(alerta), 0);
    step(2);
    set_lv(3, 3, 3, 3);
    rst_n = 1'b1;
    step(6);
    check("post_rst_cara", int'(cara), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
